// File: rtl/led_pattern_pwm.sv
// Multi-channel LED pattern generator: per-channel off / steady / blink / breathe
// modes rendered as registered PWM bits, plus a shared blink phase and period-start pulse.
module led_pattern_pwm #(
  parameter int CLK_FREQ = 12000000,
  parameter int NUM_CH   = 3,
  parameter int PWM_BITS = 8,
  parameter int BLINK_HZ = 1,
  parameter int STEP_HZ  = 512,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_level,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic                blink_phase,
  output logic                period_start
);

  localparam int HALF   = CLK_FREQ / (2 * BLINK_HZ);
  localparam int STEP   = CLK_FREQ / STEP_HZ;
  localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int STEP_W = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

  if (HALF < 1) begin : g_half_chk
    $error("led_pattern_pwm: blink half-period divisor is 0");
  end
  if (STEP < 1) begin : g_step_chk
    $error("led_pattern_pwm: breathe step divisor is 0");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_ch_chk
    $error("led_pattern_pwm: NUM_CH must be 1..16");
  end

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STEADY  = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [HALF_W-1:0]   blink_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic                step_tick;
  logic                blink_wrap;
  logic                duty_load;

  mode_t               mode_q  [NUM_CH];
  mode_t               mode_d  [NUM_CH];
  logic [PWM_BITS-1:0] level_q [NUM_CH];
  logic [PWM_BITS-1:0] level_d [NUM_CH];
  logic [PWM_BITS-1:0] ramp_q  [NUM_CH];
  logic [PWM_BITS-1:0] ramp_d  [NUM_CH];
  dir_t                dir_q   [NUM_CH];
  dir_t                dir_d   [NUM_CH];
  logic [PWM_BITS-1:0] target  [NUM_CH];
  logic [PWM_BITS-1:0] duty_q  [NUM_CH];
  logic [NUM_CH-1:0]   wr_hit;

  assign step_tick  = (step_cnt == STEP_W'(STEP - 1));
  assign blink_wrap = (blink_cnt == HALF_W'(HALF - 1));
  assign duty_load  = (pwm_cnt == '1);

  // Channel indices at or above NUM_CH never match, so such writes are dropped.
  always_comb begin
    wr_hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      mode_d[i]  = mode_q[i];
      level_d[i] = level_q[i];
      ramp_d[i]  = ramp_q[i];
      dir_d[i]   = dir_q[i];
      target[i]  = '0;

      case (mode_q[i])
        MODE_STEADY:  target[i] = level_q[i];
        MODE_BLINK:   target[i] = blink_phase ? level_q[i] : '0;
        MODE_BREATHE: target[i] = ramp_q[i];
        default:      target[i] = '0;
      endcase

      // A write takes priority over a coincident step for the same channel.
      if (wr_hit[i]) begin
        mode_d[i]  = mode_t'(cfg_mode);
        level_d[i] = cfg_level;
        if (mode_t'(cfg_mode) == MODE_BREATHE && mode_q[i] != MODE_BREATHE) begin
          ramp_d[i] = '0;
          dir_d[i]  = DIR_UP;
        end
      end else if (step_tick && mode_q[i] == MODE_BREATHE) begin
        if (level_q[i] < ramp_q[i]) begin
          ramp_d[i] = level_q[i];
          dir_d[i]  = DIR_DOWN;
        end else if (dir_q[i] == DIR_UP) begin
          if (ramp_q[i] < level_q[i]) begin
            ramp_d[i] = ramp_q[i] + ONE;
            if (ramp_d[i] == level_q[i]) dir_d[i] = DIR_DOWN;
          end else if (level_q[i] != '0) begin
            dir_d[i] = DIR_DOWN;
          end
        end else begin
          if (ramp_q[i] != '0) begin
            ramp_d[i] = ramp_q[i] - ONE;
            if (ramp_d[i] == '0) dir_d[i] = DIR_UP;
          end else begin
            dir_d[i] = DIR_UP;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt      <= '0;
      period_start <= 1'b0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      step_cnt     <= '0;
      pwm_out      <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        mode_q[i]  <= MODE_OFF;
        level_q[i] <= '0;
        ramp_q[i]  <= '0;
        dir_q[i]   <= DIR_UP;
        duty_q[i]  <= '0;
      end
    end else begin
      pwm_cnt      <= pwm_cnt + ONE;
      period_start <= duty_load;

      if (blink_wrap) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + HALF_W'(1);
      end

      if (step_tick) step_cnt <= '0;
      else           step_cnt <= step_cnt + STEP_W'(1);

      for (int unsigned i = 0; i < NUM_CH; i++) begin
        mode_q[i]  <= mode_d[i];
        level_q[i] <= level_d[i];
        ramp_q[i]  <= ramp_d[i];
        dir_q[i]   <= dir_d[i];
        // Duty only changes on the last count so each period is rendered whole.
        if (duty_load) duty_q[i] <= target[i];
        pwm_out[i] <= (pwm_cnt < duty_q[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_pwm.sv
// Directed bench for led_pattern_pwm: table of steady/off writes plus hand sequences
// for duty-load timing, blink windows, breathe ramp, level clamp and async reset.
module tb_led_pattern_pwm;

  localparam int CLK_FREQ = 1024;
  localparam int NUM_CH   = 3;
  localparam int PWM_BITS = 4;
  localparam int BLINK_HZ = 2;
  localparam int STEP_HZ  = 256;

  localparam logic [1:0] M_OFF     = 2'b00;
  localparam logic [1:0] M_STEADY  = 2'b01;
  localparam logic [1:0] M_BLINK   = 2'b10;
  localparam logic [1:0] M_BREATHE = 2'b11;

  logic        clk_in    = 1'b0;
  logic        rst_n     = 1'b0;
  logic        cfg_we    = 1'b0;
  logic [1:0]  cfg_ch    = '0;
  logic [1:0]  cfg_mode  = '0;
  logic [3:0]  cfg_level = '0;
  logic [2:0]  pwm_out;
  logic        blink_phase;
  logic        period_start;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int          cyc     = 0;

  led_pattern_pwm #(
    .CLK_FREQ (CLK_FREQ),
    .NUM_CH   (NUM_CH),
    .PWM_BITS (PWM_BITS),
    .BLINK_HZ (BLINK_HZ),
    .STEP_HZ  (STEP_HZ)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_mode     (cfg_mode),
    .cfg_level    (cfg_level),
    .pwm_out      (pwm_out),
    .blink_phase  (blink_phase),
    .period_start (period_start)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0] ch;
    logic [1:0] mode;
    logic [3:0] level;
    int         e0;
    int         e1;
    int         e2;
  } vec_t;

  localparam int NUM_VECS = 8;
  vec_t vecs [NUM_VECS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // cyc counts clock edges since the last reset release; samples land 1 unit after the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] lvl);
    cfg_we    = 1'b1;
    cfg_ch    = ch;
    cfg_mode  = mode;
    cfg_level = lvl;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic wait_ps();
    int n = 0;
    do begin
      tick();
      n++;
    end while (period_start !== 1'b1 && n < 40);
    check("period_start_wait", {31'd0, period_start}, 32'd1);
  endtask

  // Called at a period_start sample; bit j of m[c] is channel c while the counter was j.
  task automatic measure(output logic [2:0][15:0] m);
    m = '0;
    for (int j = 0; j < 16; j++) begin
      tick();
      for (int c = 0; c < 3; c++) m[c][j] = pwm_out[c];
    end
  endtask

  function automatic logic [15:0] dmask(input int d);
    logic [31:0] one = 32'd1;
    return 16'((one << d) - one);
  endfunction

  initial begin
    logic [2:0][15:0] m;
    int br_exp [4];
    int lp;
    int n;

    vecs[0] = '{2'd0, M_STEADY, 4'd5,  5,  0, 0};
    vecs[1] = '{2'd1, M_STEADY, 4'd15, 5, 15, 0};
    vecs[2] = '{2'd2, M_STEADY, 4'd1,  5, 15, 1};
    vecs[3] = '{2'd3, M_STEADY, 4'd9,  5, 15, 1};
    vecs[4] = '{2'd0, M_STEADY, 4'd0,  0, 15, 1};
    vecs[5] = '{2'd1, M_OFF,    4'd7,  0,  0, 1};
    vecs[6] = '{2'd2, M_STEADY, 4'd8,  0,  0, 8};
    vecs[7] = '{2'd0, M_STEADY, 4'd12, 12, 0, 8};
    br_exp  = '{3, 1, 1, 3};

    // Reset and free-running timebase
    rst_n = 1'b0;
    repeat (5) tick();
    check("reset_pwm", {29'd0, pwm_out}, 32'd0);
    check("reset_phase", {31'd0, blink_phase}, 32'd0);
    check("reset_ps", {31'd0, period_start}, 32'd0);
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 48; k++) begin
      tick();
      check("post_reset_ps_phase_pwm", {27'd0, period_start, blink_phase, pwm_out},
            {27'd0, (cyc % 16 == 0), 1'b0, 3'b000});
    end

    // Table: steady/off writes, including an out-of-range channel
    for (int v = 0; v < NUM_VECS; v++) begin
      cfg_write(vecs[v].ch, vecs[v].mode, vecs[v].level);
      wait_ps();
      wait_ps();
      measure(m);
      check($sformatf("vec%0d_ch0", v), {16'd0, m[0]}, {16'd0, dmask(vecs[v].e0)});
      check($sformatf("vec%0d_ch1", v), {16'd0, m[1]}, {16'd0, dmask(vecs[v].e1)});
      check($sformatf("vec%0d_ch2", v), {16'd0, m[2]}, {16'd0, dmask(vecs[v].e2)});
    end

    // Write landing on the duty-load edge shows up one period later
    wait_ps();
    repeat (15) tick();
    cfg_write(2'd0, M_STEADY, 4'd3);
    check("glitch_ps", {31'd0, period_start}, 32'd1);
    measure(m);
    check("glitch_old_duty", {16'd0, m[0]}, {16'd0, dmask(12)});
    measure(m);
    check("glitch_new_duty", {16'd0, m[0]}, {16'd0, dmask(3)});

    // Blink: duty follows the phase seen just before each load edge
    cfg_write(2'd0, M_OFF, 4'd0);
    cfg_write(2'd2, M_OFF, 4'd0);
    cfg_write(2'd1, M_BLINK, 4'd15);
    wait_ps();
    wait_ps();
    for (int p = 0; p < 40; p++) begin
      lp = cyc;
      check("blink_phase", {31'd0, blink_phase}, {31'd0, 1'((lp >> 8) & 1)});
      measure(m);
      check("blink_ch1", {16'd0, m[1]},
            {16'd0, ((((lp - 1) >> 8) & 1) != 0) ? dmask(15) : 16'h0000});
    end

    // Breathe level 3 written at counter 0: loads see ramp after steps 3,7,11,15
    cfg_write(2'd1, M_OFF, 4'd0);
    wait_ps();
    cfg_write(2'd2, M_BREATHE, 4'd3);
    wait_ps();
    for (int k = 0; k < 4; k++) begin
      measure(m);
      check($sformatf("breathe_ch2_p%0d", k), {16'd0, m[2]}, {16'd0, dmask(br_exp[k])});
    end

    // Level lowered while ramp=3 rising: clamp to 1, then 0,1,0... loads see 1
    cfg_write(2'd2, M_OFF, 4'd0);
    wait_ps();
    repeat (12) tick();
    cfg_write(2'd2, M_BREATHE, 4'd7);
    repeat (11) tick();
    cfg_write(2'd2, M_BREATHE, 4'd1);
    repeat (7) tick();
    check("lower_ps", {31'd0, period_start}, 32'd1);
    measure(m);
    check("lower_clamp_p0", {16'd0, m[2]}, {16'd0, dmask(1)});
    measure(m);
    check("lower_clamp_p1", {16'd0, m[2]}, {16'd0, dmask(1)});
    cfg_write(2'd2, M_BREATHE, 4'd0);
    wait_ps();
    wait_ps();
    measure(m);
    check("breathe_level0", {16'd0, m[2]}, 32'd0);

    // Asynchronous reset mid-pattern
    cfg_write(2'd0, M_STEADY, 4'd15);
    cfg_write(2'd1, M_STEADY, 4'd15);
    cfg_write(2'd2, M_STEADY, 4'd15);
    wait_ps();
    wait_ps();
    n = 0;
    while (pwm_out !== 3'b111 && n < 20) begin
      tick();
      n++;
    end
    check("pre_reset_pwm", {29'd0, pwm_out}, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", {29'd0, pwm_out}, 32'd0);
    check("async_rst_phase", {31'd0, blink_phase}, 32'd0);
    check("async_rst_ps", {31'd0, period_start}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    cyc   = 0;
    wait_ps();
    check("first_ps_after_reset", 32'(cyc), 32'd16);
    wait_ps();
    measure(m);
    check("after_reset_ch0", {16'd0, m[0]}, 32'd0);
    check("after_reset_ch1", {16'd0, m[1]}, 32'd0);
    check("after_reset_ch2", {16'd0, m[2]}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
